// File: rtl/whack_round_fsm.sv
// Whack-a-mole round controller: accepts a target box, flashes it for a hit
// window, scores hits/misses and ends the game after MAX_MISSES misses.
module whack_round_fsm #(
  parameter int unsigned WINDOW_CYCLES   = 50000000,
  parameter int unsigned COOLDOWN_CYCLES = 12500000,
  parameter int unsigned MAX_MISSES      = 3
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] box,
  input  logic       box_valid,
  input  logic       hit_valid,
  input  logic [2:0] hit_box,
  output logic       flash_on,
  output logic [2:0] flash_box,
  output logic [7:0] score,
  output logic [3:0] misses,
  output logic       hit_ok,
  output logic       miss,
  output logic       game_over
);

  localparam int unsigned SPAN = (WINDOW_CYCLES > COOLDOWN_CYCLES) ? WINDOW_CYCLES : COOLDOWN_CYCLES;
  localparam int unsigned TW   = (SPAN > 2) ? $clog2(SPAN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TGT,
    S_SHOW,
    S_COOLDOWN,
    S_OVER
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    flash_box_q, flash_box_d;
  logic [7:0]    score_q, score_d;
  logic [3:0]    misses_q, misses_d;
  logic          flash_on_q, flash_on_d;
  logic          hit_ok_q, hit_ok_d;
  logic          miss_q, miss_d;
  logic          game_over_q, game_over_d;
  logic [3:0]    misses_inc;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    flash_box_d = flash_box_q;
    score_d     = score_q;
    misses_d    = misses_q;
    hit_ok_d    = 1'b0;
    miss_d      = 1'b0;
    misses_inc  = misses_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_WAIT_TGT;
      end
      S_WAIT_TGT: begin
        if (box_valid && box >= 3'd2 && box <= 3'd5) begin
          flash_box_d = box;
          timer_d     = TW'(WINDOW_CYCLES - 1);
          state_d     = S_SHOW;
        end
      end
      S_SHOW: begin
        // A correct hit wins even on the timeout cycle.
        if (hit_valid && hit_box == flash_box_q) begin
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
          hit_ok_d = 1'b1;
          timer_d  = TW'(COOLDOWN_CYCLES - 1);
          state_d  = S_COOLDOWN;
        end else if (hit_valid || timer_q == '0) begin
          miss_d   = 1'b1;
          misses_d = misses_inc;
          if (misses_inc == 4'(MAX_MISSES)) begin
            state_d = S_OVER;
          end else begin
            timer_d = TW'(COOLDOWN_CYCLES - 1);
            state_d = S_COOLDOWN;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_COOLDOWN: begin
        if (timer_q == '0) state_d = S_WAIT_TGT;
        else               timer_d = timer_q - 1'b1;
      end
      S_OVER: begin
        if (start) begin
          score_d  = '0;
          misses_d = '0;
          state_d  = S_WAIT_TGT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    flash_on_d  = (state_d == S_SHOW);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      flash_box_q <= '0;
      score_q     <= '0;
      misses_q    <= '0;
      flash_on_q  <= 1'b0;
      hit_ok_q    <= 1'b0;
      miss_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      flash_box_q <= flash_box_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      flash_on_q  <= flash_on_d;
      hit_ok_q    <= hit_ok_d;
      miss_q      <= miss_d;
      game_over_q <= game_over_d;
    end
  end

  assign flash_on  = flash_on_q;
  assign flash_box = flash_box_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign hit_ok    = hit_ok_q;
  assign miss      = miss_q;
  assign game_over = game_over_q;

endmodule
